// File: rtl/banked_addr_pkg.sv
// ============================================================================
// Module      : banked_addr_pkg
// Description : Shared types and constants for the banked address sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package banked_addr_pkg;

    // Sequencer states
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Bank mapping modes
    localparam logic MAP_LINEAR = 1'b0;
    localparam logic MAP_SKEW   = 1'b1;

    // Flat element index width: bank select bits below the row address bits
    function automatic int calc_idx_w(input int bank_bits, input int addr_bits);
        return bank_bits + addr_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/banked_addr_seq_bank_map.sv
// ============================================================================
// Module      : bank_map
// Description : Combinational flat index -> {bank, row} mapping, linear or
//               diagonally skewed so that column walks spread across banks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_map
    import banked_addr_pkg::*;
#(
    parameter int BANK_BITS = 4,
    parameter int ADDR_BITS = 12
) (
    input  logic [BANK_BITS+ADDR_BITS-1:0] i_idx,
    input  logic                           i_mode,
    output logic [BANK_BITS-1:0]           o_bank,
    output logic [ADDR_BITS-1:0]           o_addr
);

    logic [BANK_BITS-1:0] w_low;

    assign o_addr = i_idx[BANK_BITS+ADDR_BITS-1:BANK_BITS];
    assign w_low  = i_idx[BANK_BITS-1:0];

    // Skew adds the low row bits to the bank select (wraps modulo bank count)
    always_comb begin
        o_bank = w_low;
        unique case (i_mode)
            MAP_LINEAR: o_bank = w_low;
            MAP_SKEW:   o_bank = w_low + o_addr[BANK_BITS-1:0];
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/banked_addr_seq.sv
// ============================================================================
// Module      : banked_addr_seq
// Description : Multi-lane burst address sequencer for the banked key/hash
//               RAMs. Issues LANES {bank,row} pairs per beat with valid/ready
//               back-pressure, abort and done signalling.
//               Optional feature macro: BANK_CONFLICT_CHK_EN (sticky
//               same-bank detection across enabled lanes of a transfer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_addr_seq
    import banked_addr_pkg::*;
#(
    parameter int BANK_BITS = 4,
    parameter int ADDR_BITS = 12,
    parameter int LANES     = 4,
    localparam int IDX_W    = calc_idx_w(BANK_BITS, ADDR_BITS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [IDX_W-1:0]           base,
    input  logic [IDX_W:0]             len,
    input  logic                       mode,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*BANK_BITS-1:0] out_bank,
    output logic [LANES*ADDR_BITS-1:0] out_addr,
    output logic [LANES-1:0]           out_lane_en,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       conflict
);

    localparam logic [IDX_W-1:0] c_lanes_idx = IDX_W'(LANES);
    localparam logic [IDX_W:0]   c_lanes_rem = (IDX_W+1)'(LANES);

    state_t                     r_state;
    logic [IDX_W-1:0]           r_cur_idx;   // first index of presented beat
    logic [IDX_W:0]             r_rem;       // elements left, incl. presented beat
    logic                       r_mode;
    logic                       r_valid;
    logic [LANES*BANK_BITS-1:0] r_bank;
    logic [LANES*ADDR_BITS-1:0] r_addr;
    logic [LANES-1:0]           r_lane_en;
    logic                       r_last;
    logic                       r_done;

    // Next beat to load: from the start inputs in IDLE, else one beat ahead
    logic [IDX_W-1:0]           w_load_idx;
    logic [IDX_W:0]             w_load_rem;
    logic                       w_load_mode;
    logic [LANES*BANK_BITS-1:0] w_bank;
    logic [LANES*ADDR_BITS-1:0] w_addr;
    logic [LANES-1:0]           w_lane_en;
    logic                       w_last;
    logic                       w_xfer;
    logic                       w_start_acc;

    assign w_load_idx  = (r_state == S_IDLE) ? base : (r_cur_idx + c_lanes_idx);
    assign w_load_rem  = (r_state == S_IDLE) ? len  : (r_rem - c_lanes_rem);
    assign w_load_mode = (r_state == S_IDLE) ? mode : r_mode;
    assign w_last      = (w_load_rem <= c_lanes_rem);
    assign w_xfer      = r_valid && out_ready && !abort;
    assign w_start_acc = (r_state == S_IDLE) && start && !abort;

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [IDX_W-1:0] w_idx;
            assign w_idx        = w_load_idx + IDX_W'(j);
            assign w_lane_en[j] = ((IDX_W+1)'(j) < w_load_rem);
            bank_map #(
                .BANK_BITS (BANK_BITS),
                .ADDR_BITS (ADDR_BITS)
            ) u_bank_map (
                .i_idx  (w_idx),
                .i_mode (w_load_mode),
                .o_bank (w_bank[j*BANK_BITS +: BANK_BITS]),
                .o_addr (w_addr[j*ADDR_BITS +: ADDR_BITS])
            );
        end
    endgenerate

    // Burst FSM: launch, beat advance on handshake, completion and abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cur_idx <= '0;
            r_rem     <= '0;
            r_mode    <= MAP_LINEAR;
            r_valid   <= 1'b0;
            r_bank    <= '0;
            r_addr    <= '0;
            r_lane_en <= '0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (len == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state   <= S_RUN;
                                r_valid   <= 1'b1;
                                r_cur_idx <= base;
                                r_rem     <= len;
                                r_mode    <= mode;
                                r_bank    <= w_bank;
                                r_addr    <= w_addr;
                                r_lane_en <= w_lane_en;
                                r_last    <= w_last;
                            end
                        end
                    end
                    S_RUN: begin
                        if (r_valid && out_ready) begin
                            if (r_last) begin
                                r_state <= S_IDLE;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_cur_idx <= w_load_idx;
                                r_rem     <= w_load_rem;
                                r_bank    <= w_bank;
                                r_addr    <= w_addr;
                                r_lane_en <= w_lane_en;
                                r_last    <= w_last;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef BANK_CONFLICT_CHK_EN
    logic w_dup;
    logic r_conflict;

    // Any two enabled lanes of the presented beat targeting the same bank
    always_comb begin
        w_dup = 1'b0;
        for (int a = 0; a < LANES; a++) begin
            for (int b = a + 1; b < LANES; b++) begin
                if (r_lane_en[a] && r_lane_en[b] &&
                    (r_bank[a*BANK_BITS +: BANK_BITS] == r_bank[b*BANK_BITS +: BANK_BITS])) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    // Sticky conflict flag, cleared when a new burst is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict <= 1'b0;
        end else if (w_start_acc) begin
            r_conflict <= 1'b0;
        end else if (w_xfer && w_dup) begin
            r_conflict <= 1'b1;
        end
    end

    assign conflict = r_conflict;
`else
    assign conflict = 1'b0;
`endif

    assign out_valid   = r_valid;
    assign out_bank    = r_bank;
    assign out_addr    = r_addr;
    assign out_lane_en = r_lane_en;
    assign out_last    = r_last;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_banked_addr_seq.sv
// ============================================================================
// Module      : tb_banked_addr_seq
// Description : Self-checking bench for banked_addr_seq (4 banks bits,
//               12 row bits, 4 lanes) against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banked_addr_seq;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base;
    logic [16:0] len;
    logic        mode;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bank;
    logic [47:0] out_addr;
    logic [3:0]  out_lane_en;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        conflict;

    int checks = 0;
    int errors = 0;
    bit exp_conf = 1'b0;

    banked_addr_seq #(
        .BANK_BITS (4),
        .ADDR_BITS (12),
        .LANES     (L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base        (base),
        .len         (len),
        .mode        (mode),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bank    (out_bank),
        .out_addr    (out_addr),
        .out_lane_en (out_lane_en),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .conflict    (conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: element e = k*L+j of the burst, index wraps modulo 2**16
    task automatic model_beat(input int b, input int n, input int m, input int k,
                              output logic [15:0] eb, output logic [47:0] ea,
                              output logic [3:0] ee, output logic el, output bit dup);
        int bk[L];
        eb = '0; ea = '0; ee = '0; dup = 1'b0;
        for (int j = 0; j < L; j++) begin
            int e, idx, ad;
            e     = k * L + j;
            idx   = (b + e) % 65536;
            ad    = idx / 16;
            bk[j] = (m != 0) ? ((idx % 16) + (ad % 16)) % 16 : idx % 16;
            ee[j] = (e < n);
            eb[j*4 +: 4]   = 4'(bk[j]);
            ea[j*12 +: 12] = 12'(ad);
        end
        for (int a = 0; a < L; a++)
            for (int c = a + 1; c < L; c++)
                if (ee[a] && ee[c] && bk[a] == bk[c]) dup = 1'b1;
        el = ((n - k * L) <= L);
    endtask

    task automatic check_beat(input int b, input int n, input int m, input int k, output bit dup);
        logic [15:0] eb, bmask;
        logic [47:0] ea, amask;
        logic [3:0]  ee;
        logic        el;
        model_beat(b, n, m, k, eb, ea, ee, el, dup);
        bmask = '0; amask = '0;
        for (int j = 0; j < L; j++) begin
            if (ee[j]) begin
                bmask[j*4 +: 4]   = 4'hF;
                amask[j*12 +: 12] = 12'hFFF;
            end
        end
        check("beat_valid", out_valid, 1'b1);
        check("beat_bank", out_bank & bmask, eb & bmask);
        check("beat_addr", out_addr & amask, ea & amask);
        check("beat_lane_en", out_lane_en, ee);
        check("beat_last", out_last, el);
        check("beat_busy", busy, 1'b1);
        check("beat_done", done, 1'b0);
        check("beat_conflict", conflict, exp_conf);
    endtask

    // Launch one burst at a negedge; returns at the negedge of the done cycle
    task automatic do_burst(input int b, input int n, input int m, input int stall, input int hold);
        int  nb, k, guard, limit, hold_left;
        bit  fire, dup;
        start = 1'b1; base = 16'(b); len = 17'(n); mode = 1'(m); out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        exp_conf = 1'b0;
        if (n == 0) begin
            check("len0_valid", out_valid, 1'b0);
            check("len0_busy", busy, 1'b0);
            check("len0_done", done, 1'b1);
            return;
        end
        nb = (n + L - 1) / L;
        k = 0; guard = 0; limit = nb * 20 + 100; hold_left = hold;
        while (k < nb && guard < limit) begin
            check_beat(b, n, m, k, dup);
            if (k == 1 && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = ($urandom_range(99) >= stall);
            end
            fire = out_ready;
            @(negedge clk);
            guard++;
            if (fire) begin
`ifdef BANK_CONFLICT_CHK_EN
                if (dup) exp_conf = 1'b1;
`endif
                k++;
            end
        end
        check("burst_beats_within_budget", 32'(k), 32'(nb));
        out_ready = 1'b0;
        check("end_valid", out_valid, 1'b0);
        check("end_busy", busy, 1'b0);
        check("end_done", done, 1'b1);
        check("end_conflict", conflict, exp_conf);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        bit dup;
        rst = 1'b1; start = 1'b0; base = '0; len = '0; mode = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_conflict", conflict, 1'b0);
        check("rst_bank", out_bank, 16'h0);
        check("rst_addr", out_addr, 48'h0);
        check("rst_lane_en", out_lane_en, 4'h0);
        rst = 1'b0;
        idle_check("idle0");

        // Linear base 0, len 8: directed constants for the first beat
        start = 1'b1; base = 16'h0000; len = 17'd8; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lin_b0_bank", out_bank, 16'h3210);
        check("lin_b0_addr", out_addr, 48'h0);
        check("lin_b0_last", out_last, 1'b0);
        @(negedge clk);
        check("lin_b1_bank", out_bank, 16'h7654);
        check("lin_b1_last", out_last, 1'b1);
        @(negedge clk);
        check("lin_done", done, 1'b1);
        check("lin_end_valid", out_valid, 1'b0);
        out_ready = 1'b0;
        idle_check("lin_after");

        // Partial beat across index wrap, skew, back-pressure, len 0, back-to-back
        do_burst(16'hFFFE, 5, 0, 0, 0);
        do_burst(16'h0010, 4, 1, 0, 0);
        do_burst(16'h0100, 16, 0, 0, 3);
        do_burst(16'h0000, 0, 0, 0, 0);
        idle_check("len0_after");
        do_burst(16'h000F, 4, 1, 0, 0);
        do_burst(16'h0020, 9, 1, 30, 0);
        idle_check("b2b_after");

        // Abort on beat 2 of 4 with a competing start
        start = 1'b1; base = 16'h0200; len = 17'd16; mode = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; exp_conf = 1'b0;
        check_beat(16'h0200, 16, 0, 0, dup);
        out_ready = 1'b1;
        @(negedge clk);
        check_beat(16'h0200, 16, 0, 1, dup);
        abort = 1'b1; start = 1'b1; base = 16'h0000; len = 17'd4;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; out_ready = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_last", out_last, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        idle_check("abort_after");

        // Random bursts
        for (int i = 0; i < 30; i++) begin
            int b, n, m, s;
            b = $urandom_range(65535);
            n = ($urandom_range(3) == 0) ? $urandom_range(3) : $urandom_range(40);
            m = $urandom_range(1);
            s = $urandom_range(60);
            do_burst(b, n, m, s, $urandom_range(2));
            if ($urandom_range(1) == 1) idle_check("rnd_idle");
        end

        // Full wrapped range
        do_burst(16'h1234, 65536, 1, 0, 0);
        idle_check("full_after");

        // Asynchronous reset mid-burst
        start = 1'b1; base = 16'h0400; len = 17'd40; mode = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_bank", out_bank, 16'h0);
        check("arst_lane_en", out_lane_en, 4'h0);
        check("arst_conflict", conflict, 1'b0);
        exp_conf = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_check("arst_after");
        do_burst(16'h0050, 6, 0, 20, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
